// File: rtl/fft_op_reorder_pkg.sv
// Shared types and constants for the FFT output reorder buffer.
package fft_op_reorder_pkg;

  localparam int unsigned FftN  = 3;
  localparam int unsigned FftW  = 16;
  localparam int unsigned FRAME = 1 << FftN;

  typedef logic signed [FftW-1:0] fpt;

  typedef struct packed {
    fpt re;
    fpt im;
  } cplx;

  typedef enum logic {StIdle, StCapture} cap_state_e;
  typedef enum logic {StEmpty, StStream} rd_state_e;

  function automatic logic [FftN-1:0] bitrev(input logic [FftN-1:0] a);
    logic [FftN-1:0] r;
    for (int i = 0; i < int'(FftN); i++) r[i] = a[FftN-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_op_reorder_if.sv
// Capture-side (bit-reversed) and stream-side (natural order) signal bundle.
interface fft_op_reorder_if #(
  parameter int unsigned N = fft_op_reorder_pkg::FftN,
  parameter int unsigned W = fft_op_reorder_pkg::FftW
);
  logic         in_start;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic [N-1:0] out_idx;
  logic         out_last;

  modport master (
    output in_start, in_re, in_im, out_ready,
    input  out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_start, in_re, in_im, out_ready,
    output out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_op_reorder_bank_ram.sv
// Two-bank simple dual-port RAM; address MSB selects the bank. Read data is
// registered and only updates on a read enable so the output holds during stalls.
module fft_op_reorder_bank_ram #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [N:0]     waddr_i,
  input  logic [2*W-1:0] wdata_i,
  input  logic           re_i,
  input  logic [N:0]     raddr_i,
  output logic [2*W-1:0] rdata_o
);

  logic [2*W-1:0] mem_q [1 << (N+1)];
  logic [2*W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_op_reorder.sv
// Ping-pong reorder sink: captures a bit-reversed FFT frame into one bank while
// the other bank streams out in natural order on a valid/ready interface.
module fft_op_reorder
  import fft_op_reorder_pkg::*;
#(
  parameter int unsigned N = fft_op_reorder_pkg::FftN,
  parameter int unsigned W = fft_op_reorder_pkg::FftW
) (
  input  logic            clk,
  input  logic            reset,
  fft_op_reorder_if.slave bus,
  output logic            overflow,
  output logic            busy
);

  localparam logic [N-1:0] LastIdx = {N{1'b1}};

  function automatic logic [N-1:0] rev_bits(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = a[N-1-i];
    return r;
  endfunction

  cap_state_e     cap_q, cap_d;
  rd_state_e      rd_st_q, rd_st_d;
  logic [N-1:0]   wcnt_q, wcnt_d, idx_q, idx_d;
  logic           wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]     full_q, full_d;
  logic           overflow_q, overflow_d, valid_q, valid_d;
  logic           we, re, set_full, clr_full;
  logic [N:0]     waddr, raddr;
  logic [2*W-1:0] rdata;

  // Capture: sample k lands at bitrev(k) so the bank reads out in natural order.
  always_comb begin
    cap_d      = cap_q;
    wcnt_d     = wcnt_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    waddr      = {wr_bank_q, rev_bits(wcnt_q)};
    set_full   = 1'b0;
    unique case (cap_q)
      StIdle: begin
        if (bus.in_start) begin
          if (!full_q[wr_bank_q]) begin
            we     = 1'b1;
            waddr  = {wr_bank_q, {N{1'b0}}};
            wcnt_d = N'(1);
            cap_d  = StCapture;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      StCapture: begin
        we = 1'b1;
        if (bus.in_start) begin
          waddr  = {wr_bank_q, {N{1'b0}}};
          wcnt_d = N'(1);
        end else begin
          wcnt_d = wcnt_q + N'(1);
          if (wcnt_q == LastIdx) begin
            set_full  = 1'b1;
            wr_bank_d = ~wr_bank_q;
            cap_d     = StIdle;
          end
        end
      end
      default: cap_d = StIdle;
    endcase
  end

  // Readout: the RAM read register is the output register, so each read is
  // issued one cycle ahead of the sample it presents.
  always_comb begin
    rd_st_d   = rd_st_q;
    idx_d     = idx_q;
    rd_bank_d = rd_bank_q;
    valid_d   = valid_q;
    re        = 1'b0;
    raddr     = {rd_bank_q, idx_q};
    clr_full  = 1'b0;
    unique case (rd_st_q)
      StEmpty: begin
        if (full_q[rd_bank_q]) begin
          re      = 1'b1;
          raddr   = {rd_bank_q, {N{1'b0}}};
          idx_d   = '0;
          valid_d = 1'b1;
          rd_st_d = StStream;
        end
      end
      StStream: begin
        if (valid_q && bus.out_ready) begin
          if (idx_q == LastIdx) begin
            clr_full  = 1'b1;
            rd_bank_d = ~rd_bank_q;
            idx_d     = '0;
            if (full_q[~rd_bank_q]) begin
              re    = 1'b1;
              raddr = {~rd_bank_q, {N{1'b0}}};
            end else begin
              valid_d = 1'b0;
              rd_st_d = StEmpty;
            end
          end else begin
            re    = 1'b1;
            raddr = {rd_bank_q, idx_q + N'(1)};
            idx_d = idx_q + N'(1);
          end
        end
      end
      default: rd_st_d = StEmpty;
    endcase
  end

  // Set and clear always target different banks, so both apply in one cycle.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wr_bank_q] = 1'b1;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q      <= StIdle;
      rd_st_q    <= StEmpty;
      wcnt_q     <= '0;
      idx_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      rd_st_q    <= rd_st_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  fft_op_reorder_bank_ram #(
    .N (N),
    .W (W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({bus.in_re, bus.in_im}),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign {bus.out_re, bus.out_im} = rdata;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = valid_q && (idx_q == LastIdx);
  assign overflow      = overflow_q;
  assign busy          = (cap_q == StCapture);

endmodule
